// File: rtl/pipe_exe_md.sv
// pipe_exe_md: EX-stage datapath with an iterative multiply/divide unit.
// Computes the ALU result, the final destination register and the jal link
// value, and owns the HI/LO registers. MULT/MULTU/DIV/DIVU run for 32
// iterations, one bit per cycle, while md_stall holds the upstream stages.
// Optional build macro: MD_EARLY_EXIT_EN lets a multiply leave RUN as soon
// as the remaining multiplier bits are all zero; divides are unaffected.
module pipe_exe_md #(
  parameter logic [31:0] DIV0_LO = 32'hFFFFFFFF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ebubble,
  input  logic [3:0]  ealuc,
  input  logic        ealuimm,
  input  logic        eshift,
  input  logic        ejal,
  input  logic [3:0]  emd,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic [31:0] eimm,
  input  logic [31:0] esa,
  input  logic [31:0] epc4,
  input  logic [4:0]  ern0,
  output logic [31:0] ealu,
  output logic [4:0]  ern,
  output logic        md_stall
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  logic [1:0]  state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] hi_q, lo_q;
  logic [31:0] opA_q, opA_d;
  logic [31:0] opB_q, opB_d;
  logic [63:0] mcand_q, mcand_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] rem_q, rem_d;
  logic        isMul_q, isMul_d;
  logic        negRes_q, negRes_d;
  logic        negA_q, negA_d;

  logic [31:0] aluA, aluB, aluRes;
  logic        mdStart, startSigned, aNeg, bNeg;
  logic [63:0] prodStep, prodFinal;
  logic [32:0] remShift, remDiff;
  logic        qBit;
  logic [31:0] remStep, quoStep, remFinal, quoFinal;
  logic        divZero, earlyDone, lastIter;

  assign aluA = eshift  ? esa  : ea;
  assign aluB = ealuimm ? eimm : eb;

  // ALU: low three opcode bits select the function, bit 3 splits SRL/SRA
  always_comb begin
    aluRes = 32'd0;
    case (ealuc[2:0])
      3'b000: aluRes = aluA + aluB;
      3'b100: aluRes = aluA - aluB;
      3'b001: aluRes = aluA & aluB;
      3'b101: aluRes = aluA | aluB;
      3'b010: aluRes = aluA ^ aluB;
      3'b110: aluRes = {aluB[15:0], 16'd0};
      3'b011: aluRes = aluB << aluA[4:0];
      3'b111: aluRes = ealuc[3] ? 32'($signed(aluB) >>> aluA[4:0])
                                : (aluB >> aluA[4:0]);
      default: aluRes = 32'd0;
    endcase
  end

  // Result mux: jal link wins, then HI/LO moves, then the ALU
  always_comb begin
    ealu = aluRes;
    ern  = ern0;
    if (ejal) begin
      ealu = epc4 + 32'd4;
      ern  = 5'd31;
    end else if (emd == MD_MFHI) begin
      ealu = hi_q;
    end else if (emd == MD_MFLO) begin
      ealu = lo_q;
    end
  end

  assign mdStart = (state_q == ST_IDLE) && !ebubble &&
                   (emd == MD_MULT || emd == MD_MULTU ||
                    emd == MD_DIV  || emd == MD_DIVU);
  assign md_stall = resetn && (mdStart || state_q == ST_RUN);

  assign startSigned = (emd == MD_MULT) || (emd == MD_DIV);
  assign aNeg = startSigned && ea[31];
  assign bNeg = startSigned && eb[31];

  // One shift-add multiply step: add the shifted multiplicand when the
  // current multiplier bit is set
  assign prodStep = prod_q + (opB_q[0] ? mcand_q : 64'd0);

  // One restoring divide step: opA_q shifts the dividend out of its top and
  // collects quotient bits at its bottom
  assign remShift = {rem_q, opA_q[31]};
  assign remDiff  = remShift - {1'b0, opB_q};
  assign qBit     = ~remDiff[32];
  assign remStep  = qBit ? remDiff[31:0] : remShift[31:0];
  assign quoStep  = {opA_q[30:0], qBit};

  // A zero divisor makes every step subtract nothing, so the remainder
  // ends up as |dividend| and the sign fix-up restores the original ea
  assign divZero   = (opB_q == 32'd0);
  assign prodFinal = negRes_q ? (64'd0 - prodStep) : prodStep;
  assign quoFinal  = negRes_q ? (32'd0 - quoStep) : quoStep;
  assign remFinal  = negA_q ? (32'd0 - remStep) : remStep;

`ifdef MD_EARLY_EXIT_EN
  assign earlyDone = isMul_q && (opB_q[31:1] == 31'd0);
`else
  assign earlyDone = 1'b0;
`endif

  assign lastIter = (count_q == 5'd31) || earlyDone;

  // Next-state logic for the md sequencer and its working registers
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    isMul_d  = isMul_q;
    negRes_d = negRes_q;
    negA_d   = negA_q;
    case (state_q)
      ST_IDLE: begin
        if (mdStart) begin
          opA_d    = aNeg ? (32'd0 - ea) : ea;
          opB_d    = bNeg ? (32'd0 - eb) : eb;
          mcand_d  = {32'd0, opA_d};
          prod_d   = 64'd0;
          rem_d    = 32'd0;
          count_d  = 5'd0;
          isMul_d  = (emd == MD_MULT) || (emd == MD_MULTU);
          negRes_d = aNeg ^ bNeg;
          negA_d   = aNeg;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (isMul_q) begin
          prod_d  = prodStep;
          mcand_d = {mcand_q[62:0], 1'b0};
          opB_d   = {1'b0, opB_q[31:1]};
        end else begin
          rem_d = remStep;
          opA_d = quoStep;
        end
        count_d = count_q + 5'd1;
        if (lastIter) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer and working-register state; reset aborts any running op
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      count_q  <= 5'd0;
      opA_q    <= 32'd0;
      opB_q    <= 32'd0;
      mcand_q  <= 64'd0;
      prod_q   <= 64'd0;
      rem_q    <= 32'd0;
      isMul_q  <= 1'b0;
      negRes_q <= 1'b0;
      negA_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      isMul_q  <= isMul_d;
      negRes_q <= negRes_d;
      negA_q   <= negA_d;
    end
  end

  // HI/LO: written by the final md iteration or by MTHI/MTLO from IDLE
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (state_q == ST_RUN && lastIter) begin
      if (isMul_q) begin
        {hi_q, lo_q} <= prodFinal;
      end else begin
        hi_q <= remFinal;
        lo_q <= divZero ? DIV0_LO : quoFinal;
      end
    end else if (state_q == ST_IDLE && !ebubble) begin
      if (emd == MD_MTHI) hi_q <= ea;
      if (emd == MD_MTLO) lo_q <= ea;
    end
  end

endmodule

// File: tb/tb_pipe_exe_md.sv
// tb_pipe_exe_md: scoreboard bench for pipe_exe_md. The driver pushes the
// expected EX result, destination and stall length of each instruction; a
// monitor pops and compares when the instruction leaves EX (md_stall low).
module tb_pipe_exe_md;

  localparam logic [31:0] TB_DIV0_LO = 32'hFFFFFFFF;

  logic        clock = 1'b0;
  logic        resetn;
  logic        ebubble;
  logic [3:0]  ealuc;
  logic        ealuimm, eshift, ejal;
  logic [3:0]  emd;
  logic [31:0] ea, eb, eimm, esa, epc4;
  logic [4:0]  ern0;
  logic [31:0] ealu;
  logic [4:0]  ern;
  logic        md_stall;

  typedef struct {
    logic [31:0] alu;
    logic [4:0]  rn;
    int          stall;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          stallCnt = 0;
  bit          monEn = 1'b0;
  logic [31:0] modelHi = 32'd0;
  logic [31:0] modelLo = 32'd0;

  pipe_exe_md #(.DIV0_LO(TB_DIV0_LO)) dut (
    .clock(clock), .resetn(resetn), .ebubble(ebubble), .ealuc(ealuc),
    .ealuimm(ealuimm), .eshift(eshift), .ejal(ejal), .emd(emd),
    .ea(ea), .eb(eb), .eimm(eimm), .esa(esa), .epc4(epc4), .ern0(ern0),
    .ealu(ealu), .ern(ern), .md_stall(md_stall)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] aluModel(input logic [3:0] c,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
    int sh;
    sh = int'(a % 32);
    casez (c)
      4'b?000: return a + b;
      4'b?100: return a - b;
      4'b?001: return a & b;
      4'b?101: return a | b;
      4'b?010: return a ^ b;
      4'b?110: return b * 32'd65536;
      4'b0011: return b << sh;
      4'b0111: return b >> sh;
      4'b1111: return (b >> sh) | (b[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
      default: return 32'd0;
    endcase
  endfunction

  function automatic int mulStall(input logic [31:0] m);
`ifdef MD_EARLY_EXIT_EN
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    if (n == 0) n = 1;
    return 1 + n;
`else
    return (m == m) ? 33 : 33;
`endif
  endfunction

  // Drive one instruction, record its expected outcome, wait for it to retire
  task automatic applyStimulus(input logic bub, input logic [3:0] aluc,
                               input logic immSel, input logic shSel,
                               input logic jal, input logic [3:0] md,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] imm, input logic [31:0] sa,
                               input logic [31:0] pc4, input logic [4:0] rn0);
    exp_t   e;
    longint sa64, sb64;
    logic [63:0] p;
    bit     done;
    e.alu = aluModel(aluc, shSel ? sa : a, immSel ? imm : b);
    e.rn  = rn0;
    e.stall = 0;
    if (jal) begin
      e.alu = pc4 + 32'd4;
      e.rn  = 5'd31;
    end else if (md == 4'd5) e.alu = modelHi;
    else if (md == 4'd6) e.alu = modelLo;
    if (!bub) begin
      case (md)
        4'd1: begin
          sa64 = longint'($signed(a));
          sb64 = longint'($signed(b));
          p = 64'(sa64 * sb64);
          {modelHi, modelLo} = p;
          e.stall = mulStall(b[31] ? -b : b);
        end
        4'd2: begin
          p = {32'd0, a} * {32'd0, b};
          {modelHi, modelLo} = p;
          e.stall = mulStall(b);
        end
        4'd3: begin
          if (b == 0) begin
            modelLo = TB_DIV0_LO;
            modelHi = a;
          end else begin
            sa64 = longint'($signed(a));
            sb64 = longint'($signed(b));
            modelLo = 32'(sa64 / sb64);
            modelHi = 32'(sa64 % sb64);
          end
          e.stall = 33;
        end
        4'd4: begin
          if (b == 0) begin
            modelLo = TB_DIV0_LO;
            modelHi = a;
          end else begin
            modelLo = a / b;
            modelHi = a % b;
          end
          e.stall = 33;
        end
        4'd7: modelHi = a;
        4'd8: modelLo = a;
        default: ;
      endcase
    end
    expQ.push_back(e);
    ebubble = bub; ealuc = aluc; ealuimm = immSel; eshift = shSel;
    ejal = jal; emd = md; ea = a; eb = b; eimm = imm; esa = sa;
    epc4 = pc4; ern0 = rn0;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (!md_stall) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) checkOutput("retire_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1;
  endtask

  // Monitor: count stall cycles, compare when the instruction leaves EX
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (monEn && resetn && expQ.size() > 0) begin
        if (md_stall) stallCnt++;
        else begin
          e = expQ.pop_front();
          checkOutput("ealu", ealu, e.alu);
          checkOutput("ern", {27'd0, ern}, {27'd0, e.rn});
          checkOutput("stall_cycles", 32'(stallCnt), 32'(e.stall));
          stallCnt = 0;
        end
      end
    end
  end

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 50));
      2: return 32'd0 - 32'($urandom_range(0, 50));
      default: begin
        case ($urandom_range(0, 4))
          0: return 32'h00000000;
          1: return 32'h00000001;
          2: return 32'hFFFFFFFF;
          3: return 32'h80000000;
          default: return 32'h7FFFFFFF;
        endcase
      end
    endcase
  endfunction

  function automatic logic [3:0] randAluc();
    case ($urandom_range(0, 8))
      0: return 4'b0000;
      1: return 4'b0100;
      2: return 4'b0001;
      3: return 4'b0101;
      4: return 4'b0010;
      5: return 4'b0110;
      6: return 4'b0011;
      7: return 4'b0111;
      default: return 4'b1111;
    endcase
  endfunction

  initial begin
    logic       bub;
    logic [3:0] md;
    resetn = 1'b0; ebubble = 1'b0; ealuc = 4'd0; ealuimm = 1'b0;
    eshift = 1'b0; ejal = 1'b0; emd = 4'd1; ea = 32'd9; eb = 32'd3;
    eimm = 32'd0; esa = 32'd0; epc4 = 32'd0; ern0 = 5'd0;
    #12;
    checkOutput("reset_stall_forced_low", {31'd0, md_stall}, 32'd0);
    emd = 4'd0;
    @(negedge clock);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    monEn = 1'b1;

    $display("[TB] directed sequence");
    applyStimulus(0, 4'b0110, 0, 0, 0, 4'd6, 32'd1, 32'd2, 0, 0, 0, 5'd4);
    applyStimulus(0, 4'b0110, 0, 0, 0, 4'd5, 32'd1, 32'd2, 0, 0, 0, 5'd4);
    applyStimulus(0, 4'b0100, 0, 0, 0, 4'd0, 32'd5, 32'd7, 0, 0, 0, 5'd9);
    applyStimulus(0, 4'b0000, 0, 0, 1, 4'd0, 32'd5, 32'd7, 0, 0, 32'h100, 5'd9);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd1, -32'd3, 32'd5, 0, 0, 0, 5'd0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd6, 0, 0, 0, 0, 0, 5'd2);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd5, 0, 0, 0, 0, 0, 5'd3);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd3, -32'd7, 32'd2, 0, 0, 0, 5'd0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd6, 0, 0, 0, 0, 0, 5'd2);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd5, 0, 0, 0, 0, 0, 5'd3);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd4, 32'd100, 32'd0, 0, 0, 0, 5'd0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd6, 0, 0, 0, 0, 0, 5'd2);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd5, 0, 0, 0, 0, 0, 5'd3);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd2, 32'd7, 32'd3, 0, 0, 0, 5'd0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd6, 0, 0, 0, 0, 0, 5'd2);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd7, 32'h1234, 0, 0, 0, 0, 5'd0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd5, 0, 0, 0, 0, 0, 5'd3);
    applyStimulus(1, 4'b0000, 0, 0, 0, 4'd1, 32'd6, 32'd6, 0, 0, 0, 5'd1);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd5, 0, 0, 0, 0, 0, 5'd3);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd6, 0, 0, 0, 0, 0, 5'd2);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd3, 32'h80000000, 32'hFFFFFFFF,
                  0, 0, 0, 5'd0);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd6, 0, 0, 0, 0, 0, 5'd2);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd5, 0, 0, 0, 0, 0, 5'd3);
    applyStimulus(0, 4'b0011, 0, 1, 0, 4'd0, 0, 32'h0F0F0001, 0, 32'd4, 0, 5'd5);
    applyStimulus(0, 4'b1111, 0, 1, 0, 4'd0, 0, 32'h80000010, 0, 32'd36, 0, 5'd6);
    applyStimulus(0, 4'b0111, 0, 1, 0, 4'd0, 0, 32'h80000010, 0, 32'd4, 0, 5'd7);
    applyStimulus(0, 4'b0110, 1, 0, 0, 4'd0, 0, 0, 32'h0000ABCD, 0, 0, 5'd8);

    $display("[TB] randomized sequence");
    for (int n = 0; n < 120; n++) begin
      bub = ($urandom_range(0, 7) == 0);
      md  = 4'($urandom_range(0, 15));
      if (bub && (md == 4'd5 || md == 4'd6)) md = 4'd0;
      applyStimulus(bub, randAluc(), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 9) == 0), md, randOperand(),
                    randOperand(), $urandom, $urandom, $urandom,
                    5'($urandom));
    end

    $display("[TB] reset during a divide");
    monEn = 1'b0;
    ebubble = 0; ejal = 0; ealuc = 4'd0; emd = 4'd4;
    ea = 32'd1000; eb = 32'd7;
    @(posedge clock);
    repeat (10) @(posedge clock);
    #1;
    checkOutput("stall_before_reset", {31'd0, md_stall}, 32'd1);
    emd = 4'd0;
    resetn = 1'b0;
    #1;
    checkOutput("stall_drops_in_reset", {31'd0, md_stall}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    expQ.delete();
    stallCnt = 0;
    modelHi = 32'd0;
    modelLo = 32'd0;
    @(posedge clock);
    #1;
    monEn = 1'b1;
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd6, 0, 0, 0, 0, 0, 5'd2);
    applyStimulus(0, 4'b0000, 0, 0, 0, 4'd5, 0, 0, 0, 0, 0, 5'd3);

    repeat (2) @(negedge clock);
    checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_exe_md.md
Name: pipe_exe_md

Overview:
- EX-stage datapath; sits directly downstream of the ID/EX pipeline register and consumes its e-prefixed outputs.
- Computes the ALU result, the destination register and the jal link value.
- Adds an iterative multiply/divide unit with HI/LO registers (MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO).
- Raises md_stall so PC, IF/ID and ID/EX hold while an md op runs; those registers gain a write enable driven by ~md_stall.

Parameters:
- DIV0_LO, 32'hFFFFFFFF, LO value written on divide by zero; HI gets the dividend.

Ports:
- clock  in  1  pipeline clock, posedge
- resetn  in  1  asynchronous active-low reset
- ebubble  in  1  EX holds a bubble; all md side effects suppressed
- ealuc  in  4  ALU op
- ealuimm  in  1  operand b = eimm when 1, else eb
- eshift  in  1  operand a = esa when 1, else ea
- ejal  in  1  jal in EX
- emd  in  4  md op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO, 9-15 none
- ea, eb, eimm, esa, epc4  in  32  operands from ID/EX
- ern0  in  5  destination from ID/EX
- ealu  out  32  EX result (combinational)
- ern  out  5  final destination (combinational)
- md_stall  out  1  hold upstream stages (combinational)

Behaviour:
- Reset: resetn=0 asynchronously sets state=IDLE, HI=LO=0, iteration count=0, internal operands=0.
  - md_stall forced 0 while resetn=0.
  - ealu/ern follow inputs combinationally.
- ALU ops:
  - ealuc x000 ADD, x100 SUB, x001 AND, x101 OR, x010 XOR, x110 LUI (b<<16).
  - 0011 SLL, 0111 SRL, 1111 SRA; shift amount = a[4:0], value = b.
  - Add/sub wrap mod 2^32; no overflow trap.
- Result mux, in priority order:
  - ejal: ealu = epc4+4, ern = 31.
  - emd=5: ealu = HI.
  - emd=6: ealu = LO.
  - Otherwise ealu = ALU result, ern = ern0.
- md FSM:
  - States: IDLE, RUN, DONE.
  - Start: IDLE with emd in 1..4 and ebubble=0.
    - md_stall=1 combinationally in that cycle.
    - At the edge: latch |ea|, |eb| (raw values for U ops) and result signs, count=0, go to RUN.
  - RUN: md_stall=1; one iteration per cycle.
    - Multiply: shift-add, one bit per iteration.
    - Divide: restoring, one bit per iteration.
    - count increments each cycle. On the edge with count=31: sign-correct, write HI/LO, go to DONE.
  - DONE: md_stall=0, so the instruction leaves EX at this edge; next state IDLE. A new md op arriving next cycle starts from IDLE.
  - Timing: an md op occupies EX for exactly 34 cycles (33 stall cycles); HI/LO valid from DONE onward.
- Multiply results:
  - {HI,LO} = 64-bit product.
  - MULT: product negated when the operand signs differ.
- Divide results:
  - LO = quotient, negated if signs differ; HI = remainder, taking the dividend's sign.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0.
  - Divisor 0: LO=DIV0_LO, HI=ea unmodified; same timing as a normal divide.
- MTHI/MTLO: write ea to HI/LO at the edge when state=IDLE and ebubble=0; no stall.
- MFHI/MFLO: never stall. Any preceding md op has already retired, so the stall guarantees freshness.
- Bubbles: with ebubble=1, emd is ignored (no start, no MT write). ealu still computes.
- Reset mid-operation: aborts the op. HI/LO become 0; the aborted instruction is not replayed.

Optional Feature:
- MD_EARLY_EXIT_EN
- Defined: multiply leaves RUN once the remaining unsigned multiplier bits are all zero.
  - RUN length = max(1, index of highest set bit of |multiplier| + 1).
  - Stall = 1 + RUN length.
  - Divide timing unchanged.
- Undefined: fixed 32 RUN cycles for all md ops.

Test Plan:
- ealuc=0100, ea=5, eb=7, ealuimm=0 -> ealu=0xFFFFFFFE, ern=ern0. ejal=1, epc4=0x100 -> ealu=0x104, ern=31.
- MULT ea=-3, eb=5 -> md_stall high 33 cycles, then MFLO=0xFFFFFFF1 and MFHI=0xFFFFFFFF. With MD_EARLY_EXIT_EN: stall 4 cycles, same result.
- DIV ea=-7, eb=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF after 33 stall cycles. DIVU ea=100, eb=0 -> LO=0xFFFFFFFF, HI=100.
- Back-to-back MULTU 7*3 then MFLO -> second instr sees md_stall=0, ealu=21. MTHI ea=0x1234 then MFHI -> 0x1234 with no stall.
- MULT with ebubble=1 -> md_stall stays 0, HI/LO unchanged.
- DIVU started, resetn pulsed low at RUN count 10 -> md_stall drops immediately; after release state=IDLE, MFLO=0.
